uart_rx_path: RTL and testbench

// Receive half of the UART duplex: 16x-oversampled serial receiver feeding an RX FIFO popped by the core.

---
 rtl/uart_rx_path_pkg.sv | 41 ++++
 rtl/uart_rx_path_if.sv | 26 ++
 rtl/uart_rx_fifo.sv | 59 +++++
 rtl/uart_rx_path.sv | 175 +++++++++++++++++
 tb/tb_uart_rx_path.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_path_pkg.sv
// Shared types and constants for the UART receive path.
// Holds the parity and FSM state enums, baud select codes and error bit indices.
// baud_div() turns a clock frequency and baud select into a rounded 16x tick divisor.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_ODD  = 2'b01,
    PAR_EVEN = 2'b10
  } parity_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam logic [1:0] BAUD_2400  = 2'b00;
  localparam logic [1:0] BAUD_4800  = 2'b01;
  localparam logic [1:0] BAUD_9600  = 2'b10;
  localparam logic [1:0] BAUD_19200 = 2'b11;

  localparam int ERR_PARITY = 0;
  localparam int ERR_START  = 1;
  localparam int ERR_STOP   = 2;

  // Rounded divisor: clock cycles per oversample tick.
  function automatic int baud_div(input int clk_hz, input logic [1:0] sel);
    int baud;
    case (sel)
      BAUD_2400: baud = 2400;
      BAUD_4800: baud = 4800;
      BAUD_9600: baud = 9600;
      default:   baud = 19200;
    endcase
    return (clk_hz + 8 * baud) / (16 * baud);
  endfunction

endpackage

// File: rtl/uart_rx_path_if.sv
// Bus bundle between the core and the UART receive path.
// Ports: rx/parity_type/baud_rate/rd_en toward the receiver; data_out, FIFO status,
// active/done/error flags and sticky overrun back to the core. slave = receiver side.
interface uart_rx_path_if;
  logic       rx;
  logic [1:0] parity_type;
  logic [1:0] baud_rate;
  logic       rd_en;
  logic [7:0] data_out;
  logic       rx_empty;
  logic       rx_full;
  logic       rx_active_flag;
  logic       rx_done_flag;
  logic [2:0] error_flag;
  logic       overrun;

  modport master (
    output rx, parity_type, baud_rate, rd_en,
    input  data_out, rx_empty, rx_full, rx_active_flag, rx_done_flag, error_flag, overrun
  );

  modport slave (
    input  rx, parity_type, baud_rate, rd_en,
    output data_out, rx_empty, rx_full, rx_active_flag, rx_done_flag, error_flag, overrun
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word-fall-through FIFO for received bytes; sync active-high reset.
// Ports: push/wdata write, pop read, rdata is the registered head (valid the cycle after
// the first write, holds its last value when empty), full/empty status. DEPTH power of 2.
module uart_rx_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_next;
  logic [AW:0]   count, count_next;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push on full is still taken.
  assign do_push = push && (!full || do_pop);
  assign rd_next = do_pop ? rd_ptr + 1'b1 : rd_ptr;

  always_comb begin
    count_next = count;
    case ({do_push, do_pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rdata  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr <= rd_next;
      count  <= count_next;
      // Next head is the byte being written when it lands in the head slot.
      if (count_next != '0)
        rdata <= (do_push && (rd_next == wr_ptr)) ? wdata : mem[rd_next];
    end
  end
endmodule

// File: rtl/uart_rx_path.sv
// UART receiver: 2-flop synchronizer, 16x tick generator, frame FSM and RX FIFO.
// Ports: clock, reset (sync active-high), bus (slave modport) carrying rx, parity/baud
// selects, rd_en pop, FWFT data_out, FIFO status, active/done/error flags and overrun.
module uart_rx_path
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int DEPTH      = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic           clock,
  input  logic           reset,
  uart_rx_path_if.slave  bus
);
  localparam int DIV_2400  = baud_div(CLK_HZ, BAUD_2400);
  localparam int DIV_4800  = baud_div(CLK_HZ, BAUD_4800);
  localparam int DIV_9600  = baud_div(CLK_HZ, BAUD_9600);
  localparam int DIV_19200 = baud_div(CLK_HZ, BAUD_19200);
  localparam logic [3:0] SAMPLE_AT = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] OS_LAST   = 4'(OVERSAMPLE - 1);

  rx_state_t   state, state_n;
  logic        rx_meta, rx_s, rx_prev;
  logic [15:0] div_cnt, div_n, div_val;
  logic [3:0]  os_cnt, os_n;
  logic [2:0]  bit_cnt, bit_n;
  logic [7:0]  shift, shift_n;
  logic [2:0]  err, err_n;
  logic        done, done_n;
  logic [1:0]  baud_q, baud_n;
  parity_t     par_q, par_n;
  logic        tick, sample;
  logic        overrun_q;
  logic        push_req;
  logic [7:0]  fifo_dat;
  logic        fifo_full, fifo_empty;

  always_comb begin
    case (baud_q)
      BAUD_2400: div_val = 16'(DIV_2400);
      BAUD_4800: div_val = 16'(DIV_4800);
      BAUD_9600: div_val = 16'(DIV_9600);
      default:   div_val = 16'(DIV_19200);
    endcase
  end

  always_comb begin
    state_n = state;
    div_n   = div_cnt;
    os_n    = os_cnt;
    bit_n   = bit_cnt;
    shift_n = shift;
    err_n   = err;
    done_n  = 1'b0;
    baud_n  = baud_q;
    par_n   = par_q;
    tick    = 1'b0;
    if (state != IDLE) begin
      if (div_cnt == div_val - 16'd1) begin
        div_n = '0;
        tick  = 1'b1;
      end else begin
        div_n = div_cnt + 16'd1;
      end
    end
    sample = tick && (os_cnt == SAMPLE_AT);
    if (tick) os_n = (os_cnt == OS_LAST) ? '0 : os_cnt + 4'd1;

    case (state)
      IDLE: begin
        // Falling edge, not low level, so a stuck-low line after a bad stop bit is not a start.
        if (rx_prev && !rx_s) begin
          state_n = START;
          div_n   = '0;
          os_n    = '0;
          bit_n   = '0;
          err_n   = '0;
          baud_n  = bus.baud_rate;
          case (bus.parity_type)
            2'b01:   par_n = PAR_ODD;
            2'b10:   par_n = PAR_EVEN;
            default: par_n = PAR_NONE;
          endcase
        end
      end
      START: begin
        if (sample) begin
          if (!rx_s) begin
            state_n = DATA;
          end else begin
            err_n[ERR_START] = 1'b1;
            done_n  = 1'b1;
            state_n = IDLE;
          end
        end
      end
      DATA: begin
        if (sample) begin
          shift_n = {rx_s, shift[7:1]};
          bit_n   = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_n = (par_q == PAR_NONE) ? STOP : PARITY;
        end
      end
      PARITY: begin
        if (sample) begin
          if (par_q == PAR_ODD) err_n[ERR_PARITY] = ~(^{shift, rx_s});
          else                  err_n[ERR_PARITY] = ^{shift, rx_s};
          state_n = STOP;
        end
      end
      STOP: begin
        if (sample) begin
          err_n[ERR_STOP] = ~rx_s;
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign push_req = done && (err == 3'b000);

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta   <= 1'b1;
      rx_s      <= 1'b1;
      rx_prev   <= 1'b1;
      state     <= IDLE;
      div_cnt   <= '0;
      os_cnt    <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      err       <= '0;
      done      <= 1'b0;
      baud_q    <= BAUD_2400;
      par_q     <= PAR_NONE;
      overrun_q <= 1'b0;
    end else begin
      rx_meta <= bus.rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
      state   <= state_n;
      div_cnt <= div_n;
      os_cnt  <= os_n;
      bit_cnt <= bit_n;
      shift   <= shift_n;
      err     <= err_n;
      done    <= done_n;
      baud_q  <= baud_n;
      par_q   <= par_n;
      // Full implies non-empty, so a same-cycle rd_en always makes room.
      if (push_req && fifo_full && !bus.rd_en) overrun_q <= 1'b1;
    end
  end

  uart_rx_fifo #(.DEPTH(DEPTH), .W(8)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push_req),
    .wdata (shift),
    .pop   (bus.rd_en),
    .rdata (fifo_dat),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.data_out       = fifo_dat;
  assign bus.rx_empty       = fifo_empty;
  assign bus.rx_full        = fifo_full;
  assign bus.rx_active_flag = (state == DATA) || (state == PARITY) || (state == STOP);
  assign bus.rx_done_flag   = done;
  assign bus.error_flag     = err;
  assign bus.overrun        = overrun_q;
endmodule

// File: tb/tb_uart_rx_path.sv
module tb_uart_rx_path;
  // CLK_HZ scaled down so 9600 baud gives DIV=(614400+76800)/153600=4, i.e. 64 clocks per bit.
  localparam int TB_CLK_HZ = 614_400;
  localparam int BIT       = 64;

  logic clock = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  int   done_cnt = 0;
  int   active_cycles = 0;
  logic [2:0] last_err = 3'b000;

  uart_rx_path_if bus();

  uart_rx_path #(.CLK_HZ(TB_CLK_HZ), .DEPTH(8), .OVERSAMPLE(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (bus.rx_done_flag) begin
      done_cnt = done_cnt + 1;
      last_err = bus.error_flag;
    end
    if (bus.rx_active_flag) active_cycles = active_cycles + 1;
  end

  task automatic drive_bit(input logic v);
    bus.rx = v;
    repeat (BIT) @(negedge clock);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit has_par, input logic par, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (has_par) drive_bit(par);
    drive_bit(stop);
  endtask

  task automatic pop_one();
    bus.rd_en = 1'b1;
    @(negedge clock);
    bus.rd_en = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.rx = 1'b1;
    bus.rd_en = 1'b0;
    bus.parity_type = 2'b10;
    bus.baud_rate = 2'b10;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    total++; if (bus.rx_empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b want=1", bus.rx_empty); end
    total++; if (bus.rx_full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b want=0", bus.rx_full); end
    total++; if (bus.data_out !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", bus.data_out); end
    total++; if (bus.rx_active_flag !== 1'b0) begin bad++; $display("FAIL reset_active got=%b want=0", bus.rx_active_flag); end
    total++; if (bus.rx_done_flag !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus.rx_done_flag); end
    total++; if (bus.error_flag !== 3'b000) begin bad++; $display("FAIL reset_err got=%b want=000", bus.error_flag); end
    total++; if (bus.overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b want=0", bus.overrun); end
  endtask

  task automatic test_even_parity();
    int d0, a0;
    d0 = done_cnt; a0 = active_cycles;
    bus.parity_type = 2'b10;
    send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
    repeat (4) @(negedge clock);
    total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL even_done got=%0d want=1", done_cnt - d0); end
    total++; if (last_err !== 3'b000) begin bad++; $display("FAIL even_err got=%b want=000", last_err); end
    total++; if (bus.data_out !== 8'hA5) begin bad++; $display("FAIL even_data got=%h want=a5", bus.data_out); end
    total++; if (bus.rx_empty !== 1'b0) begin bad++; $display("FAIL even_empty got=%b want=0", bus.rx_empty); end
    total++; if ((active_cycles > a0) !== 1'b1) begin bad++; $display("FAIL even_active got=%0d want>0", active_cycles - a0); end
    pop_one();
    total++; if (bus.rx_empty !== 1'b1) begin bad++; $display("FAIL even_pop_empty got=%b want=1", bus.rx_empty); end
  endtask

  task automatic test_odd_bad_parity();
    int d0;
    d0 = done_cnt;
    bus.parity_type = 2'b01;
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1);
    repeat (4) @(negedge clock);
    total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL odd_done got=%0d want=1", done_cnt - d0); end
    total++; if (last_err !== 3'b001) begin bad++; $display("FAIL odd_err got=%b want=001", last_err); end
    total++; if (bus.rx_empty !== 1'b1) begin bad++; $display("FAIL odd_empty got=%b want=1", bus.rx_empty); end
  endtask

  task automatic test_false_start();
    int d0, a0;
    d0 = done_cnt; a0 = active_cycles;
    bus.parity_type = 2'b10;
    bus.rx = 1'b0;
    repeat (BIT / 4) @(negedge clock);
    bus.rx = 1'b1;
    repeat (3 * BIT) @(negedge clock);
    total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL glitch_done got=%0d want=1", done_cnt - d0); end
    total++; if (last_err !== 3'b010) begin bad++; $display("FAIL glitch_err got=%b want=010", last_err); end
    total++; if (bus.rx_empty !== 1'b1) begin bad++; $display("FAIL glitch_empty got=%b want=1", bus.rx_empty); end
    total++; if (active_cycles - a0 !== 0) begin bad++; $display("FAIL glitch_active got=%0d want=0", active_cycles - a0); end
  endtask

  task automatic test_stop_error();
    int d0;
    d0 = done_cnt;
    bus.parity_type = 2'b00;
    send_frame(8'h55, 1'b0, 1'b0, 1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL stop_done got=%0d want=1", done_cnt - d0); end
    total++; if (last_err !== 3'b100) begin bad++; $display("FAIL stop_err got=%b want=100", last_err); end
    total++; if (bus.rx_empty !== 1'b1) begin bad++; $display("FAIL stop_empty got=%b want=1", bus.rx_empty); end
    send_frame(8'h12, 1'b0, 1'b0, 1'b1);
    repeat (4) @(negedge clock);
    total++; if (done_cnt - d0 !== 2) begin bad++; $display("FAIL next_done got=%0d want=2", done_cnt - d0); end
    total++; if (last_err !== 3'b000) begin bad++; $display("FAIL next_err got=%b want=000", last_err); end
    total++; if (bus.data_out !== 8'h12) begin bad++; $display("FAIL next_data got=%h want=12", bus.data_out); end
    pop_one();
  endtask

  task automatic test_back_to_back_overrun();
    int d0;
    logic [7:0] b;
    d0 = done_cnt;
    bus.parity_type = 2'b11;
    for (int i = 1; i <= 8; i++) begin
      b = 8'(i);
      send_frame(b, 1'b0, 1'b0, 1'b1);
    end
    total++; if (bus.rx_full !== 1'b1) begin bad++; $display("FAIL fill_full got=%b want=1", bus.rx_full); end
    total++; if (bus.overrun !== 1'b0) begin bad++; $display("FAIL fill_overrun got=%b want=0", bus.overrun); end
    send_frame(8'h09, 1'b0, 1'b0, 1'b1);
    repeat (4) @(negedge clock);
    total++; if (done_cnt - d0 !== 9) begin bad++; $display("FAIL b2b_done got=%0d want=9", done_cnt - d0); end
    total++; if (bus.rx_full !== 1'b1) begin bad++; $display("FAIL ovr_full got=%b want=1", bus.rx_full); end
    total++; if (bus.overrun !== 1'b1) begin bad++; $display("FAIL ovr_flag got=%b want=1", bus.overrun); end
    for (int i = 1; i <= 8; i++) begin
      b = 8'(i);
      total++; if (bus.data_out !== b) begin bad++; $display("FAIL pop_%0d got=%h want=%h", i, bus.data_out, b); end
      pop_one();
    end
    total++; if (bus.rx_empty !== 1'b1) begin bad++; $display("FAIL drain_empty got=%b want=1", bus.rx_empty); end
    pop_one();
    total++; if (bus.data_out !== 8'h08) begin bad++; $display("FAIL empty_pop_hold got=%h want=08", bus.data_out); end
    total++; if (bus.rx_empty !== 1'b1) begin bad++; $display("FAIL empty_pop_empty got=%b want=1", bus.rx_empty); end
  endtask

  task automatic test_reset_mid_frame();
    int d0;
    bus.parity_type = 2'b00;
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
    total++; if (bus.rx_empty !== 1'b0) begin bad++; $display("FAIL pre_reset_empty got=%b want=0", bus.rx_empty); end
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    drive_bit(1'b1);
    total++; if (bus.rx_active_flag !== 1'b1) begin bad++; $display("FAIL mid_active got=%b want=1", bus.rx_active_flag); end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    total++; if (bus.rx_empty !== 1'b1) begin bad++; $display("FAIL rst_empty got=%b want=1", bus.rx_empty); end
    total++; if (bus.rx_active_flag !== 1'b0) begin bad++; $display("FAIL rst_active got=%b want=0", bus.rx_active_flag); end
    total++; if (bus.overrun !== 1'b0) begin bad++; $display("FAIL rst_overrun got=%b want=0", bus.overrun); end
    total++; if (bus.data_out !== 8'h00) begin bad++; $display("FAIL rst_data got=%h want=00", bus.data_out); end
    repeat (8 * BIT) @(negedge clock);
    d0 = done_cnt;
    // Baud select changes mid-frame; the latched 9600 setting must stay in force.
    fork
      send_frame(8'h81, 1'b0, 1'b0, 1'b1);
      begin
        repeat (BIT) @(negedge clock);
        bus.baud_rate = 2'b00;
      end
    join
    repeat (4) @(negedge clock);
    bus.baud_rate = 2'b10;
    total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL after_done got=%0d want=1", done_cnt - d0); end
    total++; if (last_err !== 3'b000) begin bad++; $display("FAIL after_err got=%b want=000", last_err); end
    total++; if (bus.data_out !== 8'h81) begin bad++; $display("FAIL after_data got=%h want=81", bus.data_out); end
    total++; if (bus.rx_empty !== 1'b0) begin bad++; $display("FAIL after_empty got=%b want=0", bus.rx_empty); end
  endtask

  initial begin
    reset = 1'b1;
    bus.rx = 1'b1;
    bus.rd_en = 1'b0;
    bus.parity_type = 2'b10;
    bus.baud_rate = 2'b10;
    @(negedge clock);
    test_reset();
    test_even_parity();
    test_odd_bad_parity();
    test_false_start();
    test_stop_error();
    test_back_to_back_overrun();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
